// File: rtl/sram_nbank_ctrl_if.sv
// Bus bundle for the N-bank SRAM controller.
// Purpose: groups the host-side request/response signals and the flattened
// per-bank macro signals into one bundle.
//   slave  : the controller (takes host requests and macro read data; drives
//            host responses and macro controls)
//   master : the environment (host plus macros), with opposite directions
// Host side  : addr0/din0/csb0/web0/wmask0, dout0/dout0_valid,
//              addr1/csb1, dout1/dout1_valid, coll_count
// Macro side : m_csb0/m_web0/m_addr0/m_din0/m_wmask0/m_dout0,
//              m_csb1/m_addr1/m_dout1 (bank b data at [b*DATA_WIDTH +: DATA_WIDTH])
interface sram_nbank_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int BANK_SEL  = $clog2(NUM_BANKS);
    localparam int BANK_AW   = ADDR_WIDTH - BANK_SEL;
    localparam int NUM_WMASK = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]           addr0;
    logic [DATA_WIDTH-1:0]           din0;
    logic                            csb0;
    logic                            web0;
    logic [NUM_WMASK-1:0]            wmask0;
    logic [DATA_WIDTH-1:0]           dout0;
    logic                            dout0_valid;
    logic [ADDR_WIDTH-1:0]           addr1;
    logic                            csb1;
    logic [DATA_WIDTH-1:0]           dout1;
    logic                            dout1_valid;
    logic [CNT_WIDTH-1:0]            coll_count;

    logic [NUM_BANKS-1:0]            m_csb0;
    logic [NUM_BANKS-1:0]            m_web0;
    logic [BANK_AW-1:0]              m_addr0;
    logic [DATA_WIDTH-1:0]           m_din0;
    logic [NUM_WMASK-1:0]            m_wmask0;
    logic [NUM_BANKS*DATA_WIDTH-1:0] m_dout0;
    logic [NUM_BANKS-1:0]            m_csb1;
    logic [BANK_AW-1:0]              m_addr1;
    logic [NUM_BANKS*DATA_WIDTH-1:0] m_dout1;

    modport slave (
        input  addr0, din0, csb0, web0, wmask0, addr1, csb1, m_dout0, m_dout1,
        output dout0, dout0_valid, dout1, dout1_valid, coll_count,
        output m_csb0, m_web0, m_addr0, m_din0, m_wmask0, m_csb1, m_addr1
    );

    modport master (
        output addr0, din0, csb0, web0, wmask0, addr1, csb1, m_dout0, m_dout1,
        input  dout0, dout0_valid, dout1, dout1_valid, coll_count,
        input  m_csb0, m_web0, m_addr0, m_din0, m_wmask0, m_csb1, m_addr1
    );
endinterface

// File: rtl/sram_nbank_ctrl.sv
// N-bank controller for OpenRAM dual-port macros (port 0 RW with byte mask,
// port 1 read-only).
// Ports:
//   clk0  : single clock for the controller and all macros
//   rst_n : synchronous reset, active low
//   bus   : sram_nbank_ctrl_if.slave (host requests/responses + macro bus)
// The bank index comes from the address MSBs. Macro selects are
// combinational; bank selects are registered (S1) so returning macro data is
// steered by the bank that issued it. A port-0 write and port-1 read to the
// same address in one cycle is a collision: port 1 gets the written bytes
// forwarded, and a saturating counter records it. OUT_REG adds one more
// output stage (latency 2 instead of 1).
module sram_nbank_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 4,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             clk0,
    input  logic             rst_n,
    sram_nbank_ctrl_if.slave bus
);
    localparam int BANK_SEL  = $clog2(NUM_BANKS);
    localparam int BANK_AW   = ADDR_WIDTH - BANK_SEL;
    localparam int NUM_WMASK = DATA_WIDTH / 8;

    logic [BANK_SEL-1:0] bank0, bank1;
    assign bank0 = bus.addr0[ADDR_WIDTH-1 -: BANK_SEL];
    assign bank1 = bus.addr1[ADDR_WIDTH-1 -: BANK_SEL];

    // Per-bank selects; reset deselects every bank.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_sel
            assign bus.m_csb0[gi] = bus.csb0 | (bank0 != BANK_SEL'(gi)) | !rst_n;
            assign bus.m_web0[gi] = bus.web0 | (bank0 != BANK_SEL'(gi)) | !rst_n;
            assign bus.m_csb1[gi] = bus.csb1 | (bank1 != BANK_SEL'(gi)) | !rst_n;
        end
    endgenerate

    assign bus.m_addr0  = bus.addr0[BANK_AW-1:0];
    assign bus.m_addr1  = bus.addr1[BANK_AW-1:0];
    assign bus.m_din0   = bus.din0;
    assign bus.m_wmask0 = bus.wmask0;

    // Stage S1: request flags, bank indices and collision write data.
    logic                  rd0_reg, rd1_reg, coll_reg;
    logic [BANK_SEL-1:0]   bank0_reg, bank1_reg;
    logic [DATA_WIDTH-1:0] din0_reg;
    logic [NUM_WMASK-1:0]  wmask0_reg;
    logic [CNT_WIDTH-1:0]  coll_count_reg;

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            rd0_reg    <= 1'b0;
            rd1_reg    <= 1'b0;
            coll_reg   <= 1'b0;
            bank0_reg  <= '0;
            bank1_reg  <= '0;
            din0_reg   <= '0;
            wmask0_reg <= '0;
        end else begin
            rd0_reg    <= !bus.csb0 & bus.web0;
            rd1_reg    <= !bus.csb1;
            coll_reg   <= !bus.csb0 & !bus.web0 & !bus.csb1 & (bus.addr0 == bus.addr1);
            bank0_reg  <= bank0;
            bank1_reg  <= bank1;
            din0_reg   <= bus.din0;
            wmask0_reg <= bus.wmask0;
        end
    end

    // Saturating collision counter, stepped by the registered collision flag.
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            coll_count_reg <= '0;
        end else if (coll_reg && (coll_count_reg != {CNT_WIDTH{1'b1}})) begin
            coll_count_reg <= coll_count_reg + 1'b1;
        end
    end
    assign bus.coll_count = coll_count_reg;

    // S1 read data: steer by registered bank, then forward masked write bytes.
    logic [DATA_WIDTH-1:0] data0, slice1, data1;
    logic                  valid0, valid1;
    assign data0  = bus.m_dout0[bank0_reg*DATA_WIDTH +: DATA_WIDTH];
    assign slice1 = bus.m_dout1[bank1_reg*DATA_WIDTH +: DATA_WIDTH];

    generate
        for (genvar gi = 0; gi < NUM_WMASK; gi++) begin : g_fwd
            assign data1[gi*8 +: 8] = (coll_reg && wmask0_reg[gi]) ? din0_reg[gi*8 +: 8]
                                                                   : slice1[gi*8 +: 8];
        end
    endgenerate

    // Gating with rst_n kills the strobe of a read caught by a reset edge.
    assign valid0 = rd0_reg & rst_n;
    assign valid1 = rd1_reg & rst_n;

    generate
        if (OUT_REG == 0) begin : g_out_s1
            // Hold registers keep the last read word visible on idle cycles.
            logic [DATA_WIDTH-1:0] hold0_reg, hold1_reg;
            always_ff @(posedge clk0) begin
                if (!rst_n) begin
                    hold0_reg <= '0;
                    hold1_reg <= '0;
                end else begin
                    if (rd0_reg) hold0_reg <= data0;
                    if (rd1_reg) hold1_reg <= data1;
                end
            end
            assign bus.dout0       = valid0 ? data0 : hold0_reg;
            assign bus.dout1       = valid1 ? data1 : hold1_reg;
            assign bus.dout0_valid = valid0;
            assign bus.dout1_valid = valid1;
        end else begin : g_out_s2
            logic [DATA_WIDTH-1:0] out0_reg, out1_reg;
            logic                  vld0_reg, vld1_reg;
            always_ff @(posedge clk0) begin
                if (!rst_n) begin
                    out0_reg <= '0;
                    out1_reg <= '0;
                    vld0_reg <= 1'b0;
                    vld1_reg <= 1'b0;
                end else begin
                    vld0_reg <= valid0;
                    vld1_reg <= valid1;
                    if (valid0) out0_reg <= data0;
                    if (valid1) out1_reg <= data1;
                end
            end
            assign bus.dout0       = out0_reg;
            assign bus.dout1       = out1_reg;
            assign bus.dout0_valid = vld0_reg;
            assign bus.dout1_valid = vld1_reg;
        end
    endgenerate
endmodule

// File: tb/tb_sram_nbank_ctrl.sv
// Directed bench for sram_nbank_ctrl. Two instances share one stimulus:
// dut_a (OUT_REG=0, CNT_WIDTH=4) and dut_b (OUT_REG=1, CNT_WIDTH=16), each
// with its own behavioural model of four OpenRAM macros.
module tb_sram_nbank_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 4;

    logic clk0  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk0 = ~clk0;

    sram_nbank_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .CNT_WIDTH(4))  ifa ();
    sram_nbank_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .CNT_WIDTH(16)) ifb ();

    sram_nbank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .OUT_REG(0), .CNT_WIDTH(4))
        dut_a (.clk0(clk0), .rst_n(rst_n), .bus(ifa));
    sram_nbank_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .OUT_REG(1), .CNT_WIDTH(16))
        dut_b (.clk0(clk0), .rst_n(rst_n), .bus(ifb));

    assign ifb.addr0  = ifa.addr0;
    assign ifb.din0   = ifa.din0;
    assign ifb.csb0   = ifa.csb0;
    assign ifb.web0   = ifa.web0;
    assign ifb.wmask0 = ifa.wmask0;
    assign ifb.addr1  = ifa.addr1;
    assign ifb.csb1   = ifa.csb1;

    // Macro models: registered read, old data on read-during-write.
    logic [DW-1:0] mem_a [NB][256];
    logic [DW-1:0] mem_b [NB][256];

    always @(posedge clk0) begin
        for (int b = 0; b < NB; b++) begin
            if (!ifa.m_csb0[b]) begin
                if (!ifa.m_web0[b]) begin
                    for (int i = 0; i < 4; i++)
                        if (ifa.m_wmask0[i]) mem_a[b][ifa.m_addr0][i*8 +: 8] <= ifa.m_din0[i*8 +: 8];
                end else begin
                    ifa.m_dout0[b*DW +: DW] <= mem_a[b][ifa.m_addr0];
                end
            end
            if (!ifa.m_csb1[b]) ifa.m_dout1[b*DW +: DW] <= mem_a[b][ifa.m_addr1];
        end
    end

    always @(posedge clk0) begin
        for (int b = 0; b < NB; b++) begin
            if (!ifb.m_csb0[b]) begin
                if (!ifb.m_web0[b]) begin
                    for (int i = 0; i < 4; i++)
                        if (ifb.m_wmask0[i]) mem_b[b][ifb.m_addr0][i*8 +: 8] <= ifb.m_din0[i*8 +: 8];
                end else begin
                    ifb.m_dout0[b*DW +: DW] <= mem_b[b][ifb.m_addr0];
                end
            end
            if (!ifb.m_csb1[b]) ifb.m_dout1[b*DW +: DW] <= mem_b[b][ifb.m_addr1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %s ok: %h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        ifa.csb0 = 1'b1;
        ifa.web0 = 1'b1;
        ifa.csb1 = 1'b1;
    endtask

    task automatic wr0(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
        ifa.csb0   = 1'b0;
        ifa.web0   = 1'b0;
        ifa.addr0  = a;
        ifa.din0   = d;
        ifa.wmask0 = m;
    endtask

    logic [9:0]  bank_addr [4];
    logic [31:0] bank_data [4];

    initial begin
        bank_addr = '{10'h000, 10'h100, 10'h200, 10'h3FF};
        bank_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 256; w++) begin
                mem_a[b][w] = '0;
                mem_b[b][w] = '0;
            end
        ifa.m_dout0 = '0; ifa.m_dout1 = '0;
        ifb.m_dout0 = '0; ifb.m_dout1 = '0;
        ifa.addr0 = '0; ifa.din0 = '0; ifa.wmask0 = '0; ifa.addr1 = '0;
        idle();

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_dout0", ifa.dout0, 0);
        check("rst_valid0", {31'b0, ifa.dout0_valid}, 0);
        check("rst_coll", {28'b0, ifa.coll_count}, 0);
        check("rst_mcsb0", {28'b0, ifa.m_csb0}, 32'hF);
        rst_n = 1'b1;
        tick();

        // Defaults: write then read 0x000
        wr0(10'h000, 32'hDEADBEEF, 4'hF);
        #1;
        check("wr_mcsb0", {28'b0, ifa.m_csb0}, 32'hE);
        check("wr_mweb0", {28'b0, ifa.m_web0}, 32'hE);
        tick();
        check("wr_no_valid", {31'b0, ifa.dout0_valid}, 0);
        ifa.web0 = 1'b1;
        #1;
        check("rd_mcsb0", {28'b0, ifa.m_csb0}, 32'hE);
        check("rd_mweb0", {28'b0, ifa.m_web0}, 32'hF);
        tick();
        idle();
        check("a_rd0_valid", {31'b0, ifa.dout0_valid}, 1);
        check("a_rd0_data", ifa.dout0, 32'hDEADBEEF);
        check("b_rd0_lat", {31'b0, ifb.dout0_valid}, 0);
        tick();
        check("a_rd0_strobe", {31'b0, ifa.dout0_valid}, 0);
        check("a_rd0_hold", ifa.dout0, 32'hDEADBEEF);
        check("b_rd0_valid", {31'b0, ifb.dout0_valid}, 1);
        check("b_rd0_data", ifb.dout0, 32'hDEADBEEF);
        tick();

        // Bank decode: one word per bank, read back on port 1 back-to-back
        for (int k = 0; k < 4; k++) begin
            wr0(bank_addr[k], bank_data[k], 4'hF);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            ifa.csb1  = 1'b0;
            ifa.addr1 = bank_addr[k];
            #1;
            if (k == 3) begin
                check("mcsb1_top", {28'b0, ifa.m_csb1}, 32'h7);
                check("maddr1_top", {24'b0, ifa.m_addr1}, 32'hFF);
            end
            tick();
            check($sformatf("bank%0d_valid", k), {31'b0, ifa.dout1_valid}, 1);
            check($sformatf("bank%0d_data", k), ifa.dout1, bank_data[k]);
        end
        idle();
        tick();

        // Collision with byte mask
        wr0(10'h155, 32'hAABBCCDD, 4'hF);
        tick();
        wr0(10'h155, 32'h11223344, 4'b0101);
        ifa.csb1  = 1'b0;
        ifa.addr1 = 10'h155;
        tick();
        idle();
        check("coll_data", ifa.dout1, 32'hAA22CC44);
        tick();
        check("coll_count1", {28'b0, ifa.coll_count}, 1);
        check("b_coll_data", ifb.dout1, 32'hAA22CC44);

        // Same bank, different address: no collision; memory holds merged word
        wr0(10'h156, 32'h55667788, 4'hF);
        ifa.csb1  = 1'b0;
        ifa.addr1 = 10'h155;
        tick();
        idle();
        check("nocoll_data", ifa.dout1, 32'hAA22CC44);
        tick();
        check("nocoll_count", {28'b0, ifa.coll_count}, 1);

        // Saturation: 20 more collisions
        wr0(10'h155, 32'h0, 4'h0);
        ifa.csb1  = 1'b0;
        ifa.addr1 = 10'h155;
        for (int n = 0; n < 20; n++) tick();
        idle();
        tick();
        check("a_coll_sat", {28'b0, ifa.coll_count}, 32'hF);
        check("b_coll_cnt", {16'b0, ifb.coll_count}, 21);

        // OUT_REG=1: back-to-back port-0 reads
        ifa.csb0  = 1'b0;
        ifa.web0  = 1'b1;
        ifa.addr0 = 10'h000;
        tick();
        ifa.addr0 = 10'h100;
        check("b_bb_c1", {31'b0, ifb.dout0_valid}, 0);
        tick();
        idle();
        check("b_bb_c2_valid", {31'b0, ifb.dout0_valid}, 1);
        check("b_bb_c2_data", ifb.dout0, 32'h11111111);
        tick();
        check("b_bb_c3_valid", {31'b0, ifb.dout0_valid}, 1);
        check("b_bb_c3_data", ifb.dout0, 32'h22222222);
        tick();
        check("b_bb_c4_valid", {31'b0, ifb.dout0_valid}, 0);

        // Reset mid-read
        ifa.csb1  = 1'b0;
        ifa.addr1 = 10'h200;
        tick();
        rst_n     = 1'b0;
        ifa.csb1  = 1'b0;
        ifa.addr1 = 10'h000;
        ifa.csb0  = 1'b0;
        ifa.web0  = 1'b1;
        ifa.addr0 = 10'h000;
        #1;
        check("rst_inflight_valid", {31'b0, ifa.dout1_valid}, 0);
        check("rst_mcsb0_hi", {28'b0, ifa.m_csb0}, 32'hF);
        check("rst_mcsb1_hi", {28'b0, ifa.m_csb1}, 32'hF);
        check("rst_mweb0_hi", {28'b0, ifa.m_web0}, 32'hF);
        tick();
        check("rst_dout1", ifa.dout1, 0);
        check("rst_a_valid1", {31'b0, ifa.dout1_valid}, 0);
        check("rst_b_valid1", {31'b0, ifb.dout1_valid}, 0);
        check("rst_b_coll", {16'b0, ifb.coll_count}, 0);
        tick();
        idle();
        rst_n = 1'b1;
        check("rst_b_valid1_2", {31'b0, ifb.dout1_valid}, 0);
        tick();
        check("drop_a_valid0", {31'b0, ifa.dout0_valid}, 0);
        check("drop_a_valid1", {31'b0, ifa.dout1_valid}, 0);
        tick();
        check("drop_b_valid0", {31'b0, ifb.dout0_valid}, 0);
        check("drop_b_valid1", {31'b0, ifb.dout1_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_nbank_ctrl.md
Name: sram_nbank_ctrl

Overview:
- Parametrised N-bank controller for OpenRAM dual-port macros (port 0 read/write with byte mask, port 1 read-only).
- Decodes the bank from the address MSBs and drives a flattened per-bank macro interface.
- Registers bank selects so each read returns through a valid-qualified path; read data holds between reads.
- Forwards port-0 write data to a same-cycle, same-address port-1 read, and counts those collisions.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, total word-address width.
- NUM_BANKS, 4, bank count; power of 2, at least 2.
- BANK_SEL, log2(NUM_BANKS), number of address MSBs used as the bank index. Derived; do not override.
- BANK_AW, ADDR_WIDTH-BANK_SEL, per-macro address width. Derived.
- NUM_WMASK, DATA_WIDTH/8, byte-mask width.
- OUT_REG, 0, 1 adds an output register stage, giving read latency 2 instead of 1.
- CNT_WIDTH, 16, width of the collision counter.

Ports:
- clk0  in  1  single clock for every port and macro.
- rst_n  in  1  synchronous reset, active low.
- addr0  in  ADDR_WIDTH  port-0 address.
- din0  in  DATA_WIDTH  port-0 write data.
- csb0  in  1  port-0 chip select, active low.
- web0  in  1  port-0 write enable, active low.
- wmask0  in  NUM_WMASK  port-0 byte mask.
- dout0  out  DATA_WIDTH  port-0 read data.
- dout0_valid  out  1  one-cycle strobe marking new dout0.
- addr1  in  ADDR_WIDTH  port-1 address.
- csb1  in  1  port-1 chip select, active low.
- dout1  out  DATA_WIDTH  port-1 read data.
- dout1_valid  out  1  one-cycle strobe marking new dout1.
- m_csb0  out  NUM_BANKS  per-bank port-0 chip select.
- m_web0  out  NUM_BANKS  per-bank port-0 write enable.
- m_addr0  out  BANK_AW  shared port-0 macro address.
- m_din0  out  DATA_WIDTH  shared macro write data.
- m_wmask0  out  NUM_WMASK  shared macro byte mask.
- m_dout0  in  NUM_BANKS*DATA_WIDTH  macro port-0 data; bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH].
- m_csb1  out  NUM_BANKS  per-bank port-1 chip select.
- m_addr1  out  BANK_AW  shared port-1 macro address.
- m_dout1  in  NUM_BANKS*DATA_WIDTH  macro port-1 data, same packing as m_dout0.
- coll_count  out  CNT_WIDTH  saturating count of forwarded collisions.

Behaviour:
- Bank index: bank0 = addr0[ADDR_WIDTH-1 -: BANK_SEL]; bank1 likewise from addr1. Macro addresses are the low BANK_AW bits.
- Macro selects are combinational.
  - m_csb0[b] = csb0 | (bank0 != b) | !rst_n.
  - m_web0[b] = web0 | (bank0 != b) | !rst_n.
  - m_csb1[b] = csb1 | (bank1 != b) | !rst_n.
  - Exactly one bank at most is selected per port. While rst_n is low, no bank is selected.
- m_din0 = din0 and m_wmask0 = wmask0, passed through unconditionally.
- Stage S1 is registered on the clk0 edge of the request. It captures:
  - rd0 = !csb0 & web0;
  - rd1 = !csb1;
  - bank0_q and bank1_q;
  - coll = !csb0 & !web0 & !csb1 & (addr0 == addr1), with din0 and wmask0 registered alongside.
- Read data at S1:
  - Port 0 takes the m_dout0 slice for bank0_q.
  - Port 1 takes the m_dout1 slice for bank1_q.
  - If coll was set, each byte i of port-1 data takes the registered din0 byte where the registered wmask0[i]=1, and the macro byte otherwise.
- OUT_REG=0: dout*/dout*_valid are driven from S1. dout* is held in a data register loaded only when the S1 read flag is set, so it holds its value on idle cycles. Valid rises exactly 1 cycle after the request edge.
- OUT_REG=1: S1 results are registered once more. Valid rises 2 cycles after the request edge.
- Port-0 writes never produce dout0_valid.
- Back-to-back reads on either port are accepted every cycle, with full throughput and no stalls.
- coll_count increments by 1 on every cycle where coll is set. It saturates at 2^CNT_WIDTH-1 and never wraps.
- A port-0 write and a port-1 read in the same bank at different addresses is not a collision; both proceed.
- Reset (sync, rst_n=0 at a clk0 edge):
  - dout0, dout1, coll_count and both valid flags become 0; S1 and S2 state is cleared.
  - Requests presented while rst_n=0 are dropped: no valid strobes result later.
  - A read in flight when reset is asserted produces no valid strobe.
- A highest-address access (all-ones address) selects bank NUM_BANKS-1 at local address all-ones.

Test Plan:
- Defaults. Write 0xDEADBEEF to addr0=0x000, then read addr0=0x000 → m_csb0=4'b1110 on both cycles; dout0=0xDEADBEEF with dout0_valid high exactly 1 cycle after the read edge.
- Bank decode. Write 0x11111111, 0x22222222, 0x33333333, 0x44444444 to 0x000, 0x100, 0x200, 0x3FF, then read them back on port 1 → correct data from banks 0-3; m_addr1=0xFF for 0x3FF.
- Collision. Address 0x155 holds 0xAABBCCDD; in one cycle write din0=0x11223344 with wmask0=4'b0101 and read addr1=0x155 → dout1=0xAA22CC44; coll_count=1.
- Saturation. CNT_WIDTH=4, drive 20 consecutive collisions → coll_count stops at 15.
- OUT_REG=1. Back-to-back port-0 reads of 0x000 then 0x100 → dout0_valid in the 2nd and 3rd cycles after the first request; data 0x11111111 then 0x22222222.
- Reset mid-read. Issue read, assert rst_n=0 at the next edge → no dout1_valid; dout1=0; all m_csb* stay high while rst_n=0.
